// File: rtl/rca_share_arbiter.sv
// Round-robin time-share of one approximate ripple-carry adder; result valid SETTLE cycles after accept.
// One operation in flight: req_ready stays low outside IDLE and the response holds until rsp_ready.

module approximate_adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    // Exact majority carry; sum drops the all-ones case (1+1+1 yields sum 0).
    assign cout = (a & b) | (a & cin) | (b & cin);
    assign sum  = (a | b | cin) & ~cout;
endmodule

module ripple_carry_adder1 #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] carry;

    assign carry[0] = cin;
    for (genvar i = 0; i < N; i++) begin : g_bit
        approximate_adder1 u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end
    assign cout = carry[N];
endmodule

module rca_share_arbiter #(
    parameter int N      = 16,
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_sum,
    output logic              rsp_cout,
    input  logic              rsp_ready
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  cur_id;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  nxt_ptr;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic            op_cin;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;
    logic            sel_cin;
    logic            gnt_any;
    logic [N-1:0]    add_sum;
    logic            add_cout;
    int              idx;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
                sel_a   = req_a[idx*N +: N];
                sel_b   = req_b[idx*N +: N];
                sel_cin = req_cin[idx];
            end
        end
    end

    assign nxt_ptr   = (int'(gnt_id) + 1 == NREQ) ? '0 : gnt_id + 1'b1;
    assign req_ready = (!rst && state == S_IDLE && gnt_any) ?
                       ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id) : '0;

    ripple_carry_adder1 #(.N(N)) u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            cur_id    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_cin <= sel_cin;
                        cur_id <= gnt_id;
                        rr_ptr <= nxt_ptr;
                        cnt    <= CW'(SETTLE - 1);
                        state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        rsp_sum   <= add_sum;
                        rsp_cout  <= add_cout;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rca_share_arbiter.sv
// Directed bench for rca_share_arbiter: transaction-level model plus hand-computed literals.
`timescale 1ns/1ps
module tb_rca_share_arbiter;
    localparam int N = 16, NREQ = 4, IDW = 2, SETTLE = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*N-1:0] req_a = '0;
    logic [NREQ*N-1:0] req_b = '0;
    logic [NREQ-1:0]   req_cin = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              rsp_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    rca_share_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_cin(req_cin), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per bit: count the ones; sum is set only for exactly one, carry for two or more.
    function automatic logic [N:0] model_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        logic [N-1:0] s;
        int carry;
        int ones;
        carry = int'(c);
        for (int i = 0; i < N; i++) begin
            ones  = int'(a[i]) + int'(b[i]) + carry;
            s[i]  = (ones == 1);
            carry = (ones >= 2) ? 1 : 0;
        end
        return {carry[0], s};
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Transaction-level model: idle / busy-for-SETTLE-edges / response pending.
    int             cyc = 0;
    int             m_ptr = 0;
    bit             m_busy = 0;
    int             m_left = 0;
    bit             m_rv = 0;
    logic [IDW-1:0] m_id = '0;
    logic [N-1:0]   m_sum = '0;
    logic           m_cout = 1'b0;
    logic [N-1:0]   m_a, m_b;
    logic           m_c;
    int             m_cur = 0;
    int             acc_id[$];
    int             acc_cyc[$];
    logic [N:0]     rsp_log[$];
    int             rsp_log_id[$];
    int             rsp_cyc[$];

    initial begin
        int g;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_ptr = 0; m_busy = 0; m_left = 0; m_rv = 0;
                m_id = '0; m_sum = '0; m_cout = 1'b0;
            end else begin
                cyc++;
                if (m_rv) begin
                    if (rsp_ready) begin
                        rsp_log.push_back({rsp_cout, rsp_sum});
                        rsp_log_id.push_back(int'(rsp_id));
                        rsp_cyc.push_back(cyc);
                        m_rv = 0;
                    end
                end else if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        {m_cout, m_sum} = model_add(m_a, m_b, m_c);
                        m_id   = IDW'(m_cur);
                        m_rv   = 1;
                        m_busy = 0;
                    end
                end else begin
                    g = pick(req_valid, m_ptr);
                    if (g >= 0) begin
                        m_a = req_a[g*N +: N];
                        m_b = req_b[g*N +: N];
                        m_c = req_cin[g];
                        m_cur  = g;
                        m_ptr  = (g + 1) % NREQ;
                        m_busy = 1;
                        m_left = SETTLE;
                        acc_id.push_back(g);
                        acc_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, outputs against the model.
    initial begin
        logic [NREQ-1:0] exp_rdy;
        int g2;
        forever begin
            @(negedge clk);
            exp_rdy = '0;
            if (!rst && !m_busy && !m_rv) begin
                g2 = pick(req_valid, m_ptr);
                if (g2 >= 0) exp_rdy[g2] = 1'b1;
            end
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("rsp_valid", 64'(rsp_valid), 64'(m_rv));
            check("rsp_id",    64'(rsp_id),    64'(m_id));
            check("rsp_sum",   64'(rsp_sum),   64'(m_sum));
            check("rsp_cout",  64'(rsp_cout),  64'(m_cout));
        end
    end

    task automatic set_lane(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_cin[i]      = c;
    endtask

    task automatic do_reset();
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_acc(input string name, input int target);
        int t = 0;
        while (acc_id.size() < target && t < 60) begin @(negedge clk); t++; end
        check(name, 64'(acc_id.size() >= target), 64'(1));
        #1;
    endtask

    task automatic wait_rsp(input string name, input int target);
        int t = 0;
        while (rsp_log.size() < target && t < 60) begin @(negedge clk); t++; end
        check(name, 64'(rsp_log.size() >= target), 64'(1));
        #1;
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!rsp_valid && t < 30) begin @(negedge clk); t++; end
        check(name, 64'(rsp_valid), 64'(1));
        #1;
    endtask

    initial begin
        int ab, rb;
        // Reset: grant suppressed while held, appears on release.
        set_lane(2, 16'h1234, 16'h0001, 1'b0);
        req_valid = 4'b0100;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        #1 rst = 1'b0;
        #1 check("post_rst_grant", 64'(req_ready), 64'(4'b0100));
        wait_acc("acc_after_rst", 1);
        req_valid = '0;
        wait_rsp("rsp_after_rst", 1);
        check("rst_rsp_id", 64'(rsp_log_id[0]), 64'(2));
        check("rst_rsp_val", 64'(rsp_log[0]), 64'({1'b0, 16'h1235}));

        // Single requester, back-to-back.
        do_reset();
        set_lane(0, 16'h0, 16'h0, 1'b0);
        ab = acc_id.size(); rb = rsp_log.size();
        req_valid = 4'b0001;
        wait_acc("single_acc", ab + 2);
        req_valid = '0;
        wait_rsp("single_rsp", rb + 2);
        check("single_spacing", 64'(acc_cyc[ab+1] - acc_cyc[ab]), 64'(4));
        check("single_latency", 64'(rsp_cyc[rb] - acc_cyc[ab]), 64'(3));
        check("single_val", 64'(rsp_log[rb]), 64'(0));
        check("single_id", 64'(rsp_log_id[rb]), 64'(0));

        // Fairness with all requesters valid.
        do_reset();
        set_lane(0, 16'h0001, 16'h0001, 1'b1);
        set_lane(1, 16'hFFFF, 16'h0001, 1'b0);
        set_lane(2, 16'hFFFF, 16'h0000, 1'b0);
        set_lane(3, 16'($urandom), 16'($urandom), 1'($urandom));
        ab = acc_id.size(); rb = rsp_log.size();
        req_valid = 4'b1111;
        wait_acc("fair_acc", ab + 6);
        req_valid = '0;
        wait_rsp("fair_rsp", rb + 6);
        for (int k = 0; k < 6; k++) begin
            check("fair_order", 64'(acc_id[ab+k]), 64'(k % 4));
            check("fair_rsp_id", 64'(rsp_log_id[rb+k]), 64'(k % 4));
        end
        check("fair_lane0", 64'(rsp_log[rb]),   64'({1'b0, 16'h0002}));
        check("fair_lane1", 64'(rsp_log[rb+1]), 64'({1'b1, 16'h0000}));
        check("fair_lane2", 64'(rsp_log[rb+2]), 64'({1'b0, 16'hFFFF}));

        // Backpressure: pointer is 2 here; lane 1 alone gets served first.
        rsp_ready = 1'b0;
        set_lane(1, 16'h00F0, 16'h000F, 1'b1);
        req_valid = 4'b0010;
        wait_valid("bp_valid");
        req_valid = 4'b1111;
        rb = rsp_log.size();
        repeat (10) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(rsp_valid), 64'(1));
            check("bp_hold_sum", 64'(rsp_sum), 64'(16'h0100));
            check("bp_hold_id", 64'(rsp_id), 64'(1));
            check("bp_no_grant", 64'(req_ready), 64'(0));
        end
        #1 rsp_ready = 1'b1;
        ab = acc_id.size();
        wait_acc("bp_next_acc", ab + 1);
        check("bp_next_grant", 64'(acc_id[ab]), 64'(2));
        check("bp_one_handshake", 64'(rsp_log.size()), 64'(rb + 1));
        req_valid = '0;
        wait_rsp("bp_drain", rb + 2);

        // Skip and wrap.
        do_reset();
        ab = acc_id.size();
        req_valid = 4'b0100;
        wait_acc("skip_first", ab + 1);
        req_valid = 4'b0010;
        wait_acc("skip_second", ab + 2);
        check("skip_grant1", 64'(acc_id[ab+1]), 64'(1));
        req_valid = 4'b1010;
        wait_acc("skip_third", ab + 3);
        check("skip_grant3", 64'(acc_id[ab+2]), 64'(3));
        req_valid = '0;
        repeat (6) @(negedge clk);

        // Abort during SETTLE.
        do_reset();
        ab = acc_id.size();
        req_valid = 4'b0100;
        wait_acc("abort_acc", ab + 1);
        req_valid = '0;
        #2 rst = 1'b1;
        #1 check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        check("abort_rdy", 64'(req_ready), 64'(0));
        @(negedge clk); #1 rst = 1'b0;
        rb = rsp_log.size();
        ab = acc_id.size();
        req_valid = 4'b1111;
        wait_acc("abort_next", ab + 1);
        check("abort_first_grant", 64'(acc_id[ab]), 64'(0));
        check("abort_no_rsp", 64'(rsp_log.size()), 64'(rb));

        // Asynchronous reset while a response is held.
        req_valid = '0;
        rsp_ready = 1'b0;
        wait_valid("mid_valid");
        #2 rst = 1'b1;
        #1 check("mid_rst_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_sum", 64'(rsp_sum), 64'(0));
        check("mid_rst_cout", 64'(rsp_cout), 64'(0));
        check("mid_rst_id", 64'(rsp_id), 64'(0));
        check("mid_rst_rdy", 64'(req_ready), 64'(0));
        @(negedge clk); #1 rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not complete by %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
